ad_jesd_dac_pack: RTL and testbench

Transmit-side counterpart of the JESD204 ADC receive path: accepts two 32-bit DAC channels (two 16-bit samples each) from the DMA side, buffers them in a small FIFO and packs them into the 64-bit, two-lane JESD204 transmit word. It sits between the DAC DMA/up_dac channel logic and the JESD204 link-layer transmitter. It also provides zero and ramp test sources, offset-binary conversion, per-channel enable, and underflow reporting.

---
 rtl/ad_jesd_dac_pack_if.sv | 22 ++
 rtl/ad_jesd_dac_pack.sv | 135 +++++++++++++
 tb/tb_ad_jesd_dac_pack.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ad_jesd_dac_pack_if.sv
// DMA-side push handshake and JESD transmit-side word handshake for the DAC packer.
interface ad_jesd_dac_pack_if;
    logic        dac_valid;
    logic [31:0] dac_data_0;
    logic [31:0] dac_data_1;
    logic        dac_ready;
    logic        tx_ready;
    logic        tx_valid;
    logic [63:0] tx_data;

    // Producer of DMA samples and consumer of link words (bench / upstream logic)
    modport master (
        output dac_valid, dac_data_0, dac_data_1, tx_ready,
        input  dac_ready, tx_valid, tx_data
    );

    // The packer itself
    modport slave (
        input  dac_valid, dac_data_0, dac_data_1, tx_ready,
        output dac_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/ad_jesd_dac_pack.sv
// Two-channel DAC sample packer: small FIFO from the DMA side, zero/ramp test
// sources, offset-binary conversion and per-sample byte swap into the 64-bit,
// two-lane JESD204 transmit word.
module ad_jesd_dac_pack #(
    parameter int FIFO_AW = 2
) (
    input  logic               dac_clk,
    input  logic               dac_rst,
    input  logic               dac_enable_0,
    input  logic               dac_enable_1,
    input  logic [1:0]         dac_data_sel,
    input  logic               dac_dfmt_type,
    output logic               dac_dunf,
    output logic               dac_status,
    ad_jesd_dac_pack_if.slave  bus
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    // Disable, format and byte-swap one channel word (s0 in [15:0], s1 in [31:16]).
    function automatic logic [31:0] pack_lane(input logic [31:0] raw,
                                              input logic        en,
                                              input logic        obin);
        logic [15:0] s0;
        logic [15:0] s1;
        s0 = en ? raw[15:0]  : 16'h0000;
        s1 = en ? raw[31:16] : 16'h0000;
        if (obin) begin
            s0 = s0 ^ 16'h8000;
            s1 = s1 ^ 16'h8000;
        end
        return {s1[7:0], s1[15:8], s0[7:0], s0[15:8]};
    endfunction

    logic [63:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic [15:0]        ramp_q,   ramp_d;
    logic [63:0]        tx_data_q, tx_data_d;
    logic               tx_valid_q;
    logic               dunf_q,   dunf_d;
    logic               status_q, status_d;

    logic               ready_s;
    logic               push_s;
    logic               pop_s;
    logic               empty_s;
    logic [15:0]        ramp_p1_s;
    logic [63:0]        raw_s;

    // Push acceptance is combinational from the registered count so that a
    // pop in the same cycle cannot open a slot for a push.
    assign ready_s      = ~dac_rst & (count_q != FULL_CNT);
    assign bus.dac_ready = ready_s;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign dac_dunf      = dunf_q;
    assign dac_status    = status_q;

    // Source selection, FIFO bookkeeping, ramp and output word next-state.
    always_comb begin
        empty_s   = (count_q == '0);
        push_s    = bus.dac_valid & ready_s & (dac_data_sel == 2'd0);
        pop_s     = bus.tx_ready & (dac_data_sel == 2'd0) & ~empty_s;
        ramp_p1_s = ramp_q + 16'd1;
        raw_s     = 64'd0;
        case (dac_data_sel)
            2'd0:    raw_s = empty_s ? 64'd0 : mem_q[rd_ptr_q];
            2'd2:    raw_s = {ramp_p1_s, ramp_q, ramp_p1_s, ramp_q};
            default: raw_s = 64'd0;
        endcase

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (dac_data_sel != 2'd2) begin
            ramp_d = 16'd0;
        end else if (bus.tx_ready) begin
            ramp_d = ramp_q + 16'd2;
        end else begin
            ramp_d = ramp_q;
        end

        if (bus.tx_ready) begin
            tx_data_d = {pack_lane(raw_s[63:32], dac_enable_1, dac_dfmt_type),
                         pack_lane(raw_s[31:0],  dac_enable_0, dac_dfmt_type)};
        end else begin
            tx_data_d = tx_data_q;
        end

        dunf_d   = bus.tx_ready & (dac_data_sel == 2'd0) & empty_s &
                   (dac_enable_0 | dac_enable_1);
        status_d = status_q | bus.tx_ready;
    end

    // Control and output registers, cleared asynchronously by the link reset.
    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ramp_q     <= 16'd0;
            tx_data_q  <= 64'd0;
            tx_valid_q <= 1'b0;
            dunf_q     <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ramp_q     <= ramp_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= 1'b1;
            dunf_q     <= dunf_d;
            status_q   <= status_d;
        end
    end

    // FIFO storage; contents after reset are don't-care since the pointers are cleared.
    always_ff @(posedge dac_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.dac_data_1, bus.dac_data_0};
        end
    end

endmodule

// File: tb/tb_ad_jesd_dac_pack.sv
`timescale 1ns/1ps
module tb_ad_jesd_dac_pack;

    logic        dac_clk = 1'b0;
    logic        dac_rst;
    logic        dac_enable_0;
    logic        dac_enable_1;
    logic [1:0]  dac_data_sel;
    logic        dac_dfmt_type;
    logic        dac_dunf;
    logic        dac_status;

    ad_jesd_dac_pack_if bus ();

    ad_jesd_dac_pack #(.FIFO_AW(2)) dut (
        .dac_clk       (dac_clk),
        .dac_rst       (dac_rst),
        .dac_enable_0  (dac_enable_0),
        .dac_enable_1  (dac_enable_1),
        .dac_data_sel  (dac_data_sel),
        .dac_dfmt_type (dac_dfmt_type),
        .dac_dunf      (dac_dunf),
        .dac_status    (dac_status),
        .bus           (bus)
    );

    always #5 dac_clk = ~dac_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [64:0] exp_q [$];     // {dunf, tx_data} expected per beat
    bit          mon_en = 1'b0;
    logic [64:0] mon_e;
    logic [31:0] d0 [4];
    logic [31:0] d1 [4];
    logic [15:0] r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected lane word from two 16-bit samples (byte-swapped per sample).
    function automatic logic [31:0] lane(input logic [15:0] s0, input logic [15:0] s1);
        return {s1[7:0], s1[15:8], s0[7:0], s0[15:8]};
    endfunction

    function automatic logic [63:0] dma_word(input logic [31:0] a, input logic [31:0] b);
        return {lane(b[15:0], b[31:16]), lane(a[15:0], a[31:16])};
    endfunction

    // Scoreboard: every beat pops one expectation and compares the output word.
    always @(posedge dac_clk) begin
        if (mon_en && !dac_rst && bus.tx_ready) begin
            #1;
            chk("sb_has_exp", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("tx_data", bus.tx_data, mon_e[63:0]);
                chk("dac_dunf", 64'(dac_dunf), 64'(mon_e[64]));
                chk("tx_valid", 64'(bus.tx_valid), 64'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        dac_rst       = 1'b1;
        dac_enable_0  = 1'b1;
        dac_enable_1  = 1'b1;
        dac_data_sel  = 2'd0;
        dac_dfmt_type = 1'b0;
        bus.dac_valid  = 1'b0;
        bus.dac_data_0 = 32'd0;
        bus.dac_data_1 = 32'd0;
        bus.tx_ready   = 1'b0;
        repeat (3) @(negedge dac_clk);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_data", bus.tx_data, 64'd0);
        chk("rst_dunf", 64'(dac_dunf), 64'd0);
        chk("rst_status", 64'(dac_status), 64'd0);
        chk("rst_ready", 64'(bus.dac_ready), 64'd0);
        dac_rst = 1'b0;
        @(negedge dac_clk);
        chk("rel_tx_valid", 64'(bus.tx_valid), 64'd1);
        chk("rel_ready", 64'(bus.dac_ready), 64'd1);
        chk("rel_status", 64'(dac_status), 64'd0);

        // Single DMA word through the FIFO
        bus.dac_valid = 1'b1; bus.dac_data_0 = 32'h2222_1111; bus.dac_data_1 = 32'h4444_3333;
        @(negedge dac_clk);
        bus.dac_valid = 1'b0; bus.tx_ready = 1'b1; mon_en = 1'b1;
        exp_q.push_back({1'b0, 64'h4444_3333_2222_1111});
        @(negedge dac_clk);
        chk("status_set", 64'(dac_status), 64'd1);

        // Push into an empty FIFO on a beat: that beat underflows, word follows
        bus.dac_valid = 1'b1; bus.dac_data_0 = 32'h1234_5678; bus.dac_data_1 = 32'h9ABC_DEF0;
        exp_q.push_back({1'b1, 64'd0});
        @(negedge dac_clk);
        bus.dac_valid = 1'b0;
        exp_q.push_back({1'b0, 32'hBC9A_F0DE, 32'h3412_7856});
        @(negedge dac_clk);
        bus.tx_ready = 1'b0;

        // Fill to depth, fifth push dropped, then drain and underflow
        for (int i = 0; i < 5; i++) begin
            bus.dac_valid  = 1'b1;
            bus.dac_data_0 = $urandom;
            bus.dac_data_1 = $urandom;
            chk("fill_ready", 64'(bus.dac_ready), 64'(i < 4));
            if (i < 4) exp_q.push_back({1'b0, dma_word(bus.dac_data_0, bus.dac_data_1)});
            @(negedge dac_clk);
        end
        chk("full_ready", 64'(bus.dac_ready), 64'd0);
        bus.tx_ready = 1'b1;            // pop while full: the held push is still refused
        @(negedge dac_clk);
        bus.dac_valid = 1'b0;
        repeat (3) @(negedge dac_clk);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b1, 64'd0});
            @(negedge dac_clk);
        end
        chk("drain_ready", 64'(bus.dac_ready), 64'd1);

        // Ramp across the 16-bit wrap
        dac_data_sel = 2'd2;
        for (int k = 0; k <= 32768; k++) begin
            r = 16'(2 * k);
            exp_q.push_back({1'b0, lane(r, r + 16'd1), lane(r, r + 16'd1)});
            @(negedge dac_clk);
        end
        dac_data_sel = 2'd1; dac_dfmt_type = 1'b1;
        exp_q.push_back({1'b0, 64'h0080_0080_0080_0080});
        @(negedge dac_clk);
        dac_data_sel = 2'd2; dac_dfmt_type = 1'b0;   // ramp restarts from zero
        exp_q.push_back({1'b0, lane(16'd0, 16'd1), lane(16'd0, 16'd1)});
        @(negedge dac_clk);
        exp_q.push_back({1'b0, lane(16'd2, 16'd3), lane(16'd2, 16'd3)});
        @(negedge dac_clk);
        bus.tx_ready = 1'b0; dac_data_sel = 2'd0;

        // Offset binary with channel 1 disabled
        dac_dfmt_type = 1'b1; dac_enable_1 = 1'b0;
        bus.dac_valid = 1'b1; bus.dac_data_0 = 32'h2222_1111; bus.dac_data_1 = 32'h4444_3333;
        @(negedge dac_clk);
        bus.dac_valid = 1'b0; bus.tx_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h0080_0080, 32'h22A2_1191});
        @(negedge dac_clk);
        bus.tx_ready = 1'b0; dac_dfmt_type = 1'b0; dac_enable_1 = 1'b1;

        // Underflow suppressed with both channels disabled
        dac_enable_0 = 1'b0; dac_enable_1 = 1'b0; bus.tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 64'd0});
            @(negedge dac_clk);
        end
        dac_enable_0 = 1'b1;
        exp_q.push_back({1'b1, 64'd0});
        @(negedge dac_clk);
        bus.tx_ready = 1'b0; dac_enable_1 = 1'b1;

        // Reset mid-stream with three words held
        for (int i = 0; i < 4; i++) begin
            d0[i] = $urandom | 32'h0000_0001;
            d1[i] = $urandom;
            bus.dac_valid = 1'b1; bus.dac_data_0 = d0[i]; bus.dac_data_1 = d1[i];
            @(negedge dac_clk);
        end
        bus.dac_valid = 1'b0; bus.tx_ready = 1'b1;
        exp_q.push_back({1'b0, dma_word(d0[0], d1[0])});
        @(negedge dac_clk);
        bus.tx_ready = 1'b0;
        dac_rst = 1'b1;
        #1;
        chk("arst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("arst_tx_data", bus.tx_data, 64'd0);
        chk("arst_ready", 64'(bus.dac_ready), 64'd0);
        chk("arst_status", 64'(dac_status), 64'd0);
        chk("arst_dunf", 64'(dac_dunf), 64'd0);
        @(negedge dac_clk);
        dac_rst = 1'b0;
        @(negedge dac_clk);
        chk("rel2_status", 64'(dac_status), 64'd0);
        chk("rel2_ready", 64'(bus.dac_ready), 64'd1);
        bus.tx_ready = 1'b1;
        exp_q.push_back({1'b1, 64'd0});
        @(negedge dac_clk);
        chk("rel2_status_set", 64'(dac_status), 64'd1);
        exp_q.push_back({1'b1, 64'd0});
        @(negedge dac_clk);
        bus.tx_ready = 1'b0;
        @(negedge dac_clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
